// File: rtl/tc_operand_fetch.sv
// Operand fetch sequencer for the 2x2 tensor core: walks (i,j,k) over an nb x nb block grid,
// reads A(i,k)/B(k,j) blocks from memory and streams them to the feeder. `TC_FETCH_PERF_EN adds a stall counter.
module tc_operand_fetch #(
    parameter int ADDR_W     = 32,
    parameter int NB_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_a,
    input  logic [ADDR_W-1:0] cfg_base_b,
    input  logic [NB_W-1:0]   cfg_nb,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [31:0]       op_data,
    output logic              op_is_a,
    output logic              op_last_k,
    output logic              op_last
`ifdef TC_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [NB_W-1:0]   nb_m1;
    logic [NB_W-1:0]   i, j, k;
    logic              phase;
    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] a_row, a_addr;
    logic [ADDR_W-1:0] b_col, b_addr;

    logic [PTR_W-1:0]  tag_ptr, wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, outstanding;
    logic [31:0]       data_mem [FIFO_DEPTH];
    logic [2:0]        tag_mem  [FIFO_DEPTH];

    logic [CNT_W:0]    reserved;
    logic              grant, push, pop;
    logic              last_k_now, last_req;

    // Every granted request owns a FIFO slot until its word is popped, so the FIFO cannot overflow.
    assign reserved   = {1'b0, count} + {1'b0, outstanding};
    assign mem_req    = (state == ISSUE) && (reserved < DEPTH_L);
    assign mem_addr   = phase ? b_addr : a_addr;
    assign grant      = mem_req && mem_gnt;
    assign push       = mem_rvalid && (outstanding != '0);
    assign op_valid   = (count != '0);
    assign pop        = op_valid && op_ready;
    assign last_k_now = phase && (k == nb_m1);
    assign last_req   = last_k_now && (j == nb_m1) && (i == nb_m1);

    assign op_data = data_mem[rd_ptr];
    assign {op_last, op_last_k, op_is_a} = op_valid ? tag_mem[rd_ptr] : 3'b000;

    // Tags are written into the slot reserved at grant; data lands in the same slot later.
    always_ff @(posedge clk) begin
        if (grant) tag_mem[tag_ptr] <= {last_req, last_k_now, ~phase};
        if (push)  data_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_ptr     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
        end else begin
            if (grant) tag_ptr <= tag_ptr + PTR_W'(1);
            if (push)  wr_ptr  <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr  <= rd_ptr + PTR_W'(1);
            case ({grant, push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            nb_m1  <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            phase  <= 1'b0;
            stride <= '0;
            base_b <= '0;
            a_row  <= '0;
            a_addr <= '0;
            b_col  <= '0;
            b_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        busy   <= 1'b1;
                        nb_m1  <= cfg_nb - NB_W'(1);
                        stride <= ADDR_W'(cfg_nb) << 2;
                        base_b <= cfg_base_b;
                        a_row  <= cfg_base_a;
                        a_addr <= cfg_base_a;
                        b_col  <= cfg_base_b;
                        b_addr <= cfg_base_b;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        phase  <= 1'b0;
                        state  <= (cfg_nb != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (grant) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            // A walks along row i by 4, B walks down column j by one row stride.
                            if (k != nb_m1) begin
                                k      <= k + NB_W'(1);
                                a_addr <= a_addr + ADDR_W'(4);
                                b_addr <= b_addr + stride;
                            end else begin
                                k <= '0;
                                if (j != nb_m1) begin
                                    j      <= j + NB_W'(1);
                                    a_addr <= a_row;
                                    b_col  <= b_col + ADDR_W'(4);
                                    b_addr <= b_col + ADDR_W'(4);
                                end else begin
                                    j      <= '0;
                                    i      <= i + NB_W'(1);
                                    a_row  <= a_row + stride;
                                    a_addr <= a_row + stride;
                                    b_col  <= base_b;
                                    b_addr <= base_b;
                                    if (i == nb_m1) state <= DRAIN;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Leaving on the final handshake makes done land the very next cycle.
                    if (pop && op_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!op_valid && (outstanding == '0)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TC_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if ((state == IDLE) && cfg_start) begin
            perf_stall_cycles <= '0;
        end else if (busy && !op_valid && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tc_operand_fetch.sv
// Self-checking bench for tc_operand_fetch: memory responder, feeder sink and directed job sequences.
`timescale 1ns/1ps
module tb_tc_operand_fetch;

    typedef struct packed {
        logic [31:0] data;
        logic        is_a;
        logic        last_k;
        logic        last;
    } word_t;

    typedef struct {
        logic [31:0] addr;
        logic        is_a;
        logic        last_k;
        logic        last;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [31:0] cfg_base_a, cfg_base_b;
    logic [15:0] cfg_nb;
    logic        busy, done, mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        op_valid, op_ready, op_is_a, op_last_k, op_last;
    logic [31:0] op_data;
`ifdef TC_FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    tc_operand_fetch dut (
`ifdef TC_FETCH_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .clk(clk), .reset(reset), .cfg_start(cfg_start),
        .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_nb(cfg_nb),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .op_is_a(op_is_a), .op_last_k(op_last_k), .op_last(op_last)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt, done_cyc, last_hs_cyc, start_cyc, req_cnt, valid_cnt, stab_viol;
    int          gnt_wait = 0;
    int          max_grants = 1000000;
    bit          hold_resp = 0, rand_mode = 0, ready_rand = 0, ready_en = 1;
    bit          req_hold_v = 0, op_hold_v = 0;
    logic [31:0] req_hold_addr;
    word_t       op_hold;
    logic [31:0] gnt_log [$];
    word_t       rx [$];
    logic [31:0] pend_addr [$];
    int          pend_dly [$];
    vec_t        ref_q [$];
    vec_t        vec [16];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] gnt_at(int n);
        if (n < gnt_log.size()) return gnt_log[n];
        return 32'hDEADBEEF;
    endfunction

    function automatic word_t rx_at(int n);
        word_t w;
        w = '{data: 32'hDEADBEEF, is_a: 1'b1, last_k: 1'b1, last: 1'b1};
        if (n < rx.size()) w = rx[n];
        return w;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory responder and feeder sink, both acting mid-cycle.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; op_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!hold_resp && pend_addr.size() > 0 && pend_dly[0] == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr.pop_front());
                void'(pend_dly.pop_front());
            end else begin
                mem_rvalid = 1'b0;
            end
            foreach (pend_dly[n]) if (pend_dly[n] > 0) pend_dly[n] = pend_dly[n] - 1;

            if (req_hold_v && !reset && (!mem_req || mem_addr != req_hold_addr)) stab_viol++;
            if (mem_req && gnt_wait == 0 && gnt_log.size() < max_grants) begin
                mem_gnt = 1'b1;
                gnt_log.push_back(mem_addr);
                pend_addr.push_back(mem_addr);
                pend_dly.push_back(rand_mode ? int'($urandom_range(0, 5)) : 0);
                gnt_wait = rand_mode ? int'($urandom_range(0, 5)) : 0;
            end else begin
                mem_gnt = 1'b0;
                if (mem_req && gnt_wait > 0) gnt_wait--;
            end
            req_hold_v    = mem_req && !mem_gnt;
            req_hold_addr = mem_addr;

            op_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_en;
            if (op_hold_v && !reset && (!op_valid || {op_data, op_is_a, op_last_k, op_last} != op_hold)) stab_viol++;
            op_hold_v = op_valid && !op_ready;
            op_hold   = '{data: op_data, is_a: op_is_a, last_k: op_last_k, last: op_last};
            if (op_valid && op_ready) begin
                rx.push_back('{data: op_data, is_a: op_is_a, last_k: op_last_k, last: op_last});
                if (op_last) last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_req)  req_cnt++;
            if (op_valid) valid_cnt++;
        end
    end

    task automatic clear_logs();
        gnt_log.delete();
        rx.delete();
        done_cnt = 0; req_cnt = 0; valid_cnt = 0; stab_viol = 0;
        done_cyc = -1; last_hs_cyc = -100;
    endtask

    task automatic start_job(input logic [31:0] ba, input logic [31:0] bb, input logic [15:0] nb);
        @(negedge clk);
        cfg_base_a = ba; cfg_base_b = bb; cfg_nb = nb; cfg_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n0 = done_cnt;
        int t = 0;
        while (done_cnt == n0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({name, " done_seen"}, longint'(done_cnt != n0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic build_ref(input logic [31:0] ba, input logic [31:0] bb, input int nb);
        ref_q.delete();
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < nb; j++)
                for (int k = 0; k < nb; k++) begin
                    ref_q.push_back('{addr: ba + 32'(4 * (i * nb + k)), is_a: 1'b1, last_k: 1'b0, last: 1'b0});
                    ref_q.push_back('{addr: bb + 32'(4 * (k * nb + j)), is_a: 1'b0, last_k: (k == nb - 1),
                                      last: (k == nb - 1) && (j == nb - 1) && (i == nb - 1)});
                end
    endtask

    task automatic compare_ref(input string name);
        word_t w;
        check({name, " grants"}, gnt_log.size(), ref_q.size());
        check({name, " words"}, rx.size(), ref_q.size());
        foreach (ref_q[n]) begin
            w = rx_at(n);
            check($sformatf("%s addr[%0d]", name, n), gnt_at(n), ref_q[n].addr);
            check($sformatf("%s word[%0d]", name, n), {w.is_a, w.last_k, w.last, w.data},
                  {ref_q[n].is_a, ref_q[n].last_k, ref_q[n].last, mem_word(ref_q[n].addr)});
        end
    endtask

    task automatic load_table();
        ref_q.delete();
        for (int n = 0; n < 16; n++) ref_q.push_back(vec[n]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t held;
        int t;
        // nb=2, base_a=0x0, base_b=0x1000: {addr, is_a, last_k, last}
        vec[0]  = '{32'h0000, 1'b1, 1'b0, 1'b0};  vec[1]  = '{32'h1000, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{32'h0004, 1'b1, 1'b0, 1'b0};  vec[3]  = '{32'h1008, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{32'h0000, 1'b1, 1'b0, 1'b0};  vec[5]  = '{32'h1004, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{32'h0004, 1'b1, 1'b0, 1'b0};  vec[7]  = '{32'h100C, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{32'h0008, 1'b1, 1'b0, 1'b0};  vec[9]  = '{32'h1000, 1'b0, 1'b0, 1'b0};
        vec[10] = '{32'h000C, 1'b1, 1'b0, 1'b0};  vec[11] = '{32'h1008, 1'b0, 1'b1, 1'b0};
        vec[12] = '{32'h0008, 1'b1, 1'b0, 1'b0};  vec[13] = '{32'h1004, 1'b0, 1'b0, 1'b0};
        vec[14] = '{32'h000C, 1'b1, 1'b0, 1'b0};  vec[15] = '{32'h100C, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; cfg_start = 1'b0; cfg_base_a = '0; cfg_base_b = '0; cfg_nb = '0;
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst op_valid", op_valid, 0);
        check("rst op_is_a", op_is_a, 0);
        check("rst op_last_k", op_last_k, 0);
        check("rst op_last", op_last, 0);
        reset = 1'b0;

        // Single block: A then B, done one cycle after the last handshake
        clear_logs();
        start_job(32'h100, 32'h200, 16'd1);
        wait_done(200, "nb1");
        build_ref(32'h100, 32'h200, 1);
        compare_ref("nb1");
        check("nb1 done_latency", done_cyc - last_hs_cyc, 1);
        check("nb1 done_pulses", done_cnt, 1);
        check("nb1 busy_after", busy, 0);

        // nb=2 reference order from the hand table
        clear_logs();
        start_job(32'h0, 32'h1000, 16'd2);
        wait_done(400, "nb2");
        load_table();
        compare_ref("nb2");
        check("nb2 done_latency", done_cyc - last_hs_cyc, 1);

        // Feeder stalled: only FIFO_DEPTH grants, outputs hold, then full drain
        clear_logs();
        ready_en = 1'b0;
        start_job(32'h0, 32'h1000, 16'd2);
        repeat (20) @(negedge clk);
        check("stall grants", gnt_log.size(), 4);
        check("stall mem_req", mem_req, 0);
        check("stall op_valid", op_valid, 1);
        check("stall words", rx.size(), 0);
        held = '{data: op_data, is_a: op_is_a, last_k: op_last_k, last: op_last};
        repeat (3) @(negedge clk);
        check("stall hold", {op_data, op_is_a, op_last_k, op_last}, held);
        ready_en = 1'b1;
        wait_done(400, "stall");
        load_table();
        compare_ref("stall");
        check("stall stable", stab_viol, 0);

        // nb=0: no requests, done two cycles after start
        clear_logs();
        start_job(32'h40, 32'h80, 16'd0);
        check("nb0 busy", busy, 1);
        wait_done(20, "nb0");
        check("nb0 done_latency", done_cyc - start_cyc, 2);
        check("nb0 requests", req_cnt, 0);
        check("nb0 busy_after", busy, 0);

        // nb=3 with an ignored second start carrying different config
        clear_logs();
        start_job(32'h4000, 32'h8000, 16'd3);
        repeat (10) @(negedge clk);
        start_job(32'h10, 32'h20, 16'd1);
        wait_done(2000, "nb3");
        build_ref(32'h4000, 32'h8000, 3);
        compare_ref("nb3");
        repeat (5) @(negedge clk);
        check("nb3 done_pulses", done_cnt, 1);
        check("nb3 busy_after", busy, 0);

        // Address wrap with random grant/response delays and random ready
        clear_logs();
        rand_mode = 1'b1; ready_rand = 1'b1;
        start_job(32'hFFFF_FFFC, 32'h0030_0000, 16'd2);
        wait_done(3000, "wrap");
        rand_mode = 1'b0; ready_rand = 1'b0;
        build_ref(32'hFFFF_FFFC, 32'h0030_0000, 2);
        compare_ref("wrap");
        check("wrap a_zero", gnt_at(2), 32'h0);
        check("wrap stable", stab_viol, 0);
        repeat (10) @(negedge clk);

        // Reset with two reads in flight; their late responses must be dropped
        clear_logs();
        hold_resp = 1'b1; max_grants = 2;
        start_job(32'h500, 32'h600, 16'd2);
        t = 0;
        while (gnt_log.size() < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rstmid grants", gnt_log.size(), 2);
        repeat (2) @(negedge clk);
        check("rstmid op_valid_before", op_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_resp = 1'b0; max_grants = 1000000;
        valid_cnt = 0;
        repeat (10) @(negedge clk);
        check("rstmid op_valid_cycles", valid_cnt, 0);
        check("rstmid busy", busy, 0);
        check("rstmid words", rx.size(), 0);

        clear_logs();
        start_job(32'h700, 32'h780, 16'd1);
        wait_done(200, "post");
        build_ref(32'h700, 32'h780, 1);
        compare_ref("post");
        check("post done_latency", done_cyc - last_hs_cyc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tc_operand_fetch.md
Name: tc_operand_fetch

Overview:
- Sequences operand delivery to the 2x2 tensor-core feeder for one matrix-multiply job.
- Walks every output 2x2 tile and every k-block, reading packed A and B blocks from word memory over a req/gnt interface.
- Streams the blocks to the core feeder as strictly alternating A/B words with a valid/ready handshake, plus tile-end and job-end markers.
- Sits between the configuration registers / memory port and the core's operand inputs (inA/inB).

Parameters:
- ADDR_W, 32, memory byte-address width.
- NB_W, 16, width of the blocks-per-side count (matrix size / 2).
- FIFO_DEPTH, 4, response buffer depth in words; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_base_a  in  ADDR_W  byte address of A block 0; sampled at start.
- cfg_base_b  in  ADDR_W  byte address of B block 0; sampled at start.
- cfg_nb  in  NB_W  blocks per side (nb = size/2); sampled at start.
- busy  out  1  high from the cycle after an accepted start until DONE is exited.
- done  out  1  one-cycle pulse when the job's last word has been accepted.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  read byte address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; responses return in order, never before their grant.
- mem_rdata  in  32  packed 2x2 block {x11,x12,x21,x22}, MSB first.
- op_valid  out  1  operand word available.
- op_ready  in  1  feeder accepts the word.
- op_data  out  32  operand word.
- op_is_a  out  1  1 = A block, 0 = B block.
- op_last_k  out  1  word is the B block of the final k of the current tile.
- op_last  out  1  word is the final word of the job.

Behaviour:
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, op_valid=0, op_is_a=0, op_last_k=0, op_last=0. Reset also clears the FIFO, the outstanding counter and all loop indices.
- States:
  - IDLE: on cfg_start, go to ISSUE if cfg_nb != 0, else go to DONE.
  - ISSUE: go to DRAIN when the last request is granted.
  - DRAIN: go to DONE when the FIFO is empty and the outstanding count is 0.
  - DONE: assert done for 1 cycle, then return to IDLE.
- Request order: loop i = 0..nb-1, then j = 0..nb-1, then k = 0..nb-1 (i outermost). Each (i,j,k) issues A(i,k) first, then B(k,j).
- Total requests per job: 2*nb^3.
- Addresses:
  - A(i,k) = base_a + 4*(i*nb + k).
  - B(k,j) = base_b + 4*(k*nb + j).
  - Computed modulo 2^ADDR_W; wrap-around is legal and not flagged.
  - Implement with incremental adders, no multipliers.
- Request handshake: mem_req and mem_addr stay stable until mem_gnt. Indices advance only on the grant.
- Flow control: mem_req is asserted only while (FIFO count + outstanding) < FIFO_DEPTH, so the FIFO never overflows.
- Outstanding counter:
  - +1 on grant, -1 on rvalid.
  - A grant and an rvalid in the same cycle leave it unchanged.
- Tags: op_is_a, op_last_k and op_last are captured into a tag FIFO at grant and paired with the data at rvalid.
- op_valid = FIFO not empty (first-word-fall-through). A push and a pop in the same cycle are allowed when the FIFO is full.
- Latency: a response accepted into an empty FIFO appears on op_* the next cycle.
- op_* outputs hold stable while op_valid=1 and op_ready=0.
- cfg_start while busy (or while in DONE) is ignored and does not alter the configuration.
- done asserts exactly 1 cycle after the handshake of the word with op_last=1.
- Reset mid-job: abandon the job immediately and return to IDLE next cycle. Late mem_rvalid beats after reset are discarded (outstanding = 0).

Optional Feature:
- Macro: TC_FETCH_PERF_EN.
- Defined: adds output perf_stall_cycles (32 bits), with reset 0 and clear on accepted start.
  - Increments each busy cycle with op_valid=0; saturates at all-ones.
- Undefined: port absent, no counter logic.

Test Plan:
- nb=1, base_a=0x100, base_b=0x200, zero-wait memory, op_ready=1 -> requests 0x100 then 0x200.
  - Two words out: A, then B with op_last_k=1 and op_last=1.
  - done pulses 1 cycle after the B handshake.
- nb=2, base_a=0x0, base_b=0x1000 -> 16 requests in this order:
  - A addrs 0x0,0x4,0x0,0x4,0x8,0xC,0x8,0xC
  - interleaved with B addrs 0x1000,0x1008,0x1004,0x100C,0x1000,0x1008,0x1004,0x100C.
  - op_last_k on words 4, 8, 12, 16.
- nb=2, op_ready held 0 for 20 cycles -> exactly FIFO_DEPTH=4 grants occur, then mem_req drops.
  - On release, all 16 words are delivered in order with no loss or duplication.
- nb=0 start -> no mem_req; done pulses 2 cycles after start. A second cfg_start issued during an nb=3 job is ignored (54 words total).
- base_a=0xFFFFFFFC, nb=2 -> A addresses wrap to 0x00000000. Random gnt/rvalid delays (0-5 cycles) produce a data sequence matching the reference order.
- Reset asserted mid-job with 2 outstanding reads, then those rvalids arrive -> op_valid stays 0 and busy=0. A subsequent nb=1 job completes normally.
